// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multi-cycle control FSM and the datapath/memory side.
// Latency: n/a (wiring only). Backpressure: mem_ready from the memory side stalls the FSM.
// Ports: opcode/mem_ready flow into the controller; strobes, selects, trap pulses,
//        retire count and debug state flow out. master = controller, slave = datapath.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;

    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                MemToReg;
    logic                IRWrite;
    logic                RegWrite;
    logic                RegDst;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [1:0]          PCSource;

    logic                illegal_op;
    logic                mem_fault;
    logic                instr_done;
    logic [CNT_W-1:0]    instr_count;
    logic [3:0]          state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_fault, instr_done, instr_count, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_fault, instr_done, instr_count, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main control FSM with illegal-opcode and memory-timeout traps.
// Latency: beq/j 3, R/addi/sw 4, lw 5 cycles when mem_ready is always high.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; traps after WAIT_MAX cycles (0 = never).
// Ports: clk, reset (sync, active-high), bus (master modport): opcode/mem_ready in;
//        datapath strobes/selects, illegal_op/mem_fault/instr_done pulses, instr_count, state out.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int ENABLE_ADDI = 1,
    parameter int WAIT_MAX    = 15,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);
    localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t            st;
    logic [WCNT_W-1:0] wait_cnt;
    logic              cause_fault;   // latched trap cause: 1 = mem timeout, 0 = illegal opcode
    logic [CNT_W-1:0]  count;
    logic              waiting;
    logic              timeout;
    logic              done;

    assign waiting = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
    // mem_ready in the last allowed cycle still completes the access.
    assign timeout = (WAIT_MAX > 0) && waiting && !bus.mem_ready && (wait_cnt == WAIT_LAST);
    assign done    = (st == MEMWB) || (st == RWB) || (st == BRANCH) || (st == JUMP) ||
                     (st == ADDIWB) || ((st == MEMWR) && bus.mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= FETCH;
            wait_cnt    <= '0;
            count       <= '0;
            cause_fault <= 1'b0;
        end else begin
            if (done)
                count <= count + CNT_W'(1);

            // Outside the memory states the counter sits at zero, so every entry starts fresh.
            if (waiting && !bus.mem_ready)
                wait_cnt <= wait_cnt + WCNT_W'(1);
            else
                wait_cnt <= '0;

            case (st)
                FETCH, MEMRD, MEMWR: begin
                    if (bus.mem_ready) begin
                        if (st == FETCH)      st <= DECODE;
                        else if (st == MEMRD) st <= MEMWB;
                        else                  st <= FETCH;
                    end else if (timeout) begin
                        st          <= TRAP;
                        cause_fault <= 1'b1;
                    end
                end
                DECODE: begin
                    if (bus.opcode == OP_RTYPE)                         st <= EXEC;
                    else if (bus.opcode == OP_LW || bus.opcode == OP_SW) st <= MEMADR;
                    else if (bus.opcode == OP_BEQ)                      st <= BRANCH;
                    else if (bus.opcode == OP_J)                        st <= JUMP;
                    else if (ENABLE_ADDI != 0 && bus.opcode == OP_ADDI) st <= ADDIEX;
                    else begin
                        st          <= TRAP;
                        cause_fault <= 1'b0;
                    end
                end
                MEMADR: begin
                    // Opcode is re-sampled here; a value that is neither lw nor sw traps.
                    if (bus.opcode == OP_LW)      st <= MEMRD;
                    else if (bus.opcode == OP_SW) st <= MEMWR;
                    else begin
                        st          <= TRAP;
                        cause_fault <= 1'b0;
                    end
                end
                EXEC:    st <= RWB;
                ADDIEX:  st <= ADDIWB;
                default: st <= FETCH;   // MEMWB, RWB, BRANCH, JUMP, ADDIWB, TRAP
            endcase
        end
    end

    assign bus.state       = st;
    assign bus.instr_count = reset ? '0 : count;

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal_op  = 1'b0;
        bus.mem_fault   = 1'b0;
        bus.instr_done  = 1'b0;
        if (!reset) begin
            bus.instr_done = done;
            case (st)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                DECODE: bus.ALUSrcB = 2'b11;
                MEMADR, ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemToReg = 1'b1;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                RWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                end
                JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                ADDIWB:  bus.RegWrite = 1'b1;
                TRAP: begin
                    bus.illegal_op = !cause_fault;
                    bus.mem_fault  = cause_fault;
                end
                default: ;
            endcase
        end
    end
endmodule
